board_input_ctrl: RTL and testbench
===================================

BOARD_INPUT_CTRL -- requirements
Module: board_input_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 SHALL have parameter N_BTN, default 4: number of pushbutton channels.
REQ-003 SHALL have parameter N_SW, default 4: number of slide-switch channels.
REQ-004 SHALL have parameter PAGES, default 4: number of independent address counters.
REQ-005 SHALL have parameter ADDR_W, default 5: width of each address counter.
REQ-006 SHALL have parameter DB_CYCLES, default 10000: debounce stability count, minimum 2.
REQ-007 SHALL have parameter RST_STRETCH, default 16: reset hold cycles, minimum 1.
REQ-008 SHALL have parameter WRAP, default 1: 1 means address wraps, 0 means address saturates.
REQ-009 SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- btn_i  in  N_BTN  raw buttons
- sw_i  in  N_SW  raw switches
- rot_a, rot_b  in  1  raw rotary encoder phases
- rst_req_i  in  1  raw reset button
- locked_i  in  1  PLL lock
- page_sel  in  clog2(PAGES)  selects the active address counter
- btn_lvl  out  N_BTN  debounced button levels
- btn_pulse  out  N_BTN  one-cycle pulse on each debounced rising edge
- sw_o  out  N_SW  debounced switches
- addr_o  out  ADDR_W  address counter of the selected page
- rst_out  out  1  stretched system reset

Function
REQ-010 Every raw input SHALL pass through a 2-flop synchroniser, then a debounce counter.
REQ-011 A debounced output SHALL change only after the synchronised input has differed from it for DB_CYCLES consecutive cycles.
REQ-012 A raw change held stable SHALL reach the debounced output exactly DB_CYCLES+2 cycles later.
REQ-013 Any glitch back to the current output value SHALL clear that channel's counter.
REQ-014 btn_pulse[i] SHALL be high for exactly one cycle, on the cycle btn_lvl[i] goes 0->1; a 1->0 transition SHALL produce no pulse.
REQ-015 Rotary decoding SHALL use debounced A/B:
- rising edge of A while B low: decrement the counter of page page_sel
- rising edge of B while A low: increment the counter of page page_sel
- both rising in the same cycle: no change
REQ-016 With WRAP=1, arithmetic SHALL be modulo 2^ADDR_W.
REQ-017 With WRAP=0, the counter SHALL hold at 0 on decrement and at 2^ADDR_W-1 on increment.
REQ-018 Only the page selected at the edge cycle SHALL be updated; a page_sel change SHALL never alter any stored counter.
REQ-019 addr_o SHALL be combinational from page_sel and the stored counters, with zero latency.
REQ-020 rst_out SHALL be high while either of the following is true, and for RST_STRETCH cycles after both are cleared:
- debounced rst_req_i is high
- synchronised locked_i is low
REQ-021 Re-assertion of either rst_out source during the stretch SHALL restart the full stretch.

Reset
REQ-022 On rst, outputs and state SHALL take these values:
- synchronisers, debounced levels and counters: 0
- btn_pulse: 0
- all page counters: 0
- rst_out: 1, with the stretch counter loaded to RST_STRETCH
REQ-023 rst asserted mid-debounce or mid-stretch SHALL abort the operation immediately; after deassertion, debouncing SHALL restart from zero.
REQ-024 The address counters SHALL also be cleared synchronously while rst_out is high.

Configuration
REQ-025 With macro BTN_AUTO_REPEAT_EN defined, a button held at btn_lvl=1 SHALL additionally pulse btn_pulse as follows:
- first repeat pulse 2^20 cycles after the initial pulse
- further pulses every 2^18 cycles thereafter
- the repeat timer is cleared on release
REQ-026 Without BTN_AUTO_REPEAT_EN, REQ-014 SHALL hold exactly, and no repeat logic SHALL be synthesised.

Structure
REQ-027 A shared package SHALL hold:
- default parameter constants
- the repeat interval constants
- the rotary-direction encoding (NONE, INC, DEC)
REQ-028 Per-channel synchroniser+debouncer SHALL be one sub-module, debounce_ch, instantiated for:
- N_BTN buttons
- N_SW switches
- rotary phases A and B
- rst_req_i

Verification (DB_CYCLES=4, RST_STRETCH=3, PAGES=4, ADDR_W=5)
REQ-029 Button debounce:
- btn_i[1] 0->1 held → btn_lvl[1]=1 exactly 6 cycles later, and btn_pulse[1] high for 1 cycle
- a 3-cycle glitch → no change
REQ-030 Rotary wrap:
- page_sel=2, WRAP=1, one B-first step from counter 31 → addr_o=0; pages 0, 1, 3 unchanged
- a second step → addr_o=1
REQ-031 Rotary saturation:
- WRAP=0, counter 0, A-first step → addr_o stays 0
- A and B rising in the same cycle → no change
REQ-032 Page isolation: set page 1 to 7, switch page_sel to 3 → addr_o=0; switch back to 1 → addr_o=7.
REQ-033 Reset stretch:
- locked_i low for 10 cycles then high → rst_out deasserts exactly 3+2 cycles after locked_i rises
- locked_i glitching low mid-stretch → stretch restarts
REQ-034 Async reset: assert rst mid-debounce → all outputs at their REQ-022 values within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/board_input_ctrl_pkg.sv
// Shared constants and types for board_input_ctrl.
// Optional feature macro: BTN_AUTO_REPEAT_EN (button auto-repeat).
package board_input_ctrl_pkg;

    localparam int DEF_N_BTN       = 4;
    localparam int DEF_N_SW        = 4;
    localparam int DEF_PAGES       = 4;
    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_DB_CYCLES   = 10000;
    localparam int DEF_RST_STRETCH = 16;
    localparam int DEF_WRAP        = 1;

    // Auto-repeat timing: first repeat after 2^20 cycles, then every 2^18.
    localparam int REP_FIRST_CYCLES  = 1 << 20;
    localparam int REP_PERIOD_CYCLES = 1 << 18;
    localparam int REP_CNT_W         = 21;

    typedef enum logic [1:0] {
        ROT_NONE = 2'd0,
        ROT_INC  = 2'd1,
        ROT_DEC  = 2'd2
    } rot_dir_e;

    // A rising while B is low steps down, B rising while A is low steps up;
    // simultaneous rises cancel out.
    function automatic rot_dir_e rot_decode(input logic i_a, input logic i_a_q,
                                            input logic i_b, input logic i_b_q);
        logic w_rise_a;
        logic w_rise_b;
        w_rise_a = i_a & ~i_a_q;
        w_rise_b = i_b & ~i_b_q;
        if (w_rise_a && !w_rise_b && !i_b)
            return ROT_DEC;
        else if (w_rise_b && !w_rise_a && !i_a)
            return ROT_INC;
        else
            return ROT_NONE;
    endfunction

endpackage

// File: rtl/board_input_ctrl_debounce_ch.sv
// One raw input channel: two-flop synchroniser plus stability-count debouncer.
module debounce_ch
    import board_input_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_lvl
);

    localparam int              CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_lvl;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise, then accept a new level only after DB_CYCLES differing cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_lvl  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments let r_sync see the old r_meta, forming a real two-stage pipe.
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_lvl <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_lvl = r_lvl;

endmodule

// File: rtl/board_input_ctrl.sv
// Board input front end: debounced buttons/switches, rotary-driven paged
// address counters and a stretched system reset.
// Optional feature macro: BTN_AUTO_REPEAT_EN adds button auto-repeat pulses.
module board_input_ctrl
    import board_input_ctrl_pkg::*;
#(
    parameter int N_BTN       = DEF_N_BTN,
    parameter int N_SW        = DEF_N_SW,
    parameter int PAGES       = DEF_PAGES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int RST_STRETCH = DEF_RST_STRETCH,
    parameter int WRAP        = DEF_WRAP,
    localparam int PS_W       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_i,
    input  logic [N_SW-1:0]   sw_i,
    input  logic              rot_a,
    input  logic              rot_b,
    input  logic              rst_req_i,
    input  logic              locked_i,
    input  logic [PS_W-1:0]   page_sel,
    output logic [N_BTN-1:0]  btn_lvl,
    output logic [N_BTN-1:0]  btn_pulse,
    output logic [N_SW-1:0]   sw_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              rst_out
);

    localparam int N_CH  = N_BTN + N_SW + 3;
    localparam int CH_A  = N_BTN + N_SW;
    localparam int CH_B  = CH_A + 1;
    localparam int CH_RQ = CH_A + 2;
    localparam int ST_W  = $clog2(RST_STRETCH + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [N_CH-1:0]   w_raw;
    logic [N_CH-1:0]   w_db;
    logic [N_BTN-1:0]  r_btn_q;
    logic [N_BTN-1:0]  w_rise;
    logic              r_a_q;
    logic              r_b_q;
    rot_dir_e          w_dir;
    logic              r_lock_meta;
    logic              r_lock_sync;
    logic              w_src;
    logic [ST_W-1:0]   r_stretch;
    logic [ADDR_W-1:0] r_page [PAGES];
    logic              w_sel_ok;
    logic [ADDR_W-1:0] w_next;

    assign w_raw = {rst_req_i, rot_b, rot_a, sw_i, btn_i};

    for (genvar g = 0; g < N_CH; g++) begin : g_db
        debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .i_raw (w_raw[g]),
            .o_lvl (w_db[g])
        );
    end

    assign btn_lvl = w_db[N_BTN-1:0];
    assign sw_o    = w_db[N_BTN +: N_SW];
    assign w_rise  = btn_lvl & ~r_btn_q;

    // Previous debounced levels for button and rotary edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_q <= '0;
            r_a_q   <= 1'b0;
            r_b_q   <= 1'b0;
        end else begin
            r_btn_q <= btn_lvl;
            r_a_q   <= w_db[CH_A];
            r_b_q   <= w_db[CH_B];
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    logic [REP_CNT_W-1:0] r_rep_cnt [N_BTN];
    logic [N_BTN-1:0]     r_rep_first;
    logic [N_BTN-1:0]     w_rep;

    // A repeat fires when a held button's timer reaches the current interval.
    always_comb begin
        // NOTE: the default assignment ahead of the loop keeps this block free of latches.
        w_rep = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rep[i] = btn_lvl[i] && (r_rep_cnt[i] == (r_rep_first[i] ? REP_CNT_W'(REP_FIRST_CYCLES)
                                                                      : REP_CNT_W'(REP_PERIOD_CYCLES)));
        end
    end

    // Repeat timers run while held and clear on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) r_rep_cnt[i] <= '0;
            r_rep_first <= '1;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_lvl[i]) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_first[i] <= 1'b1;
                end else if (w_rep[i]) begin
                    r_rep_cnt[i]   <= REP_CNT_W'(1);
                    r_rep_first[i] <= 1'b0;
                end else begin
                    r_rep_cnt[i]   <= r_rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_pulse = w_rise | w_rep;
`else
    assign btn_pulse = w_rise;
`endif

    // Reset sources: debounced reset button, or PLL lock lost (sync only).
    assign w_src   = w_db[CH_RQ] | ~r_lock_sync;
    assign rst_out = w_src | (r_stretch != '0);

    // Hold the stretch counter full while a source is active, then count down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_stretch   <= ST_W'(RST_STRETCH);
        end else begin
            r_lock_meta <= locked_i;
            r_lock_sync <= r_lock_meta;
            if (w_src)
                r_stretch <= ST_W'(RST_STRETCH);
            else if (r_stretch != '0)
                r_stretch <= r_stretch - 1'b1;
        end
    end

    assign w_dir    = rot_decode(w_db[CH_A], r_a_q, w_db[CH_B], r_b_q);
    assign w_sel_ok = int'(page_sel) < PAGES;
    assign addr_o   = w_sel_ok ? r_page[page_sel] : '0;

    // Next value of the selected page: wrap or saturate at the ends.
    always_comb begin
        w_next = addr_o;
        case (w_dir)
            ROT_INC: if (WRAP != 0 || addr_o != ADDR_MAX) w_next = addr_o + 1'b1;
            ROT_DEC: if (WRAP != 0 || addr_o != '0)       w_next = addr_o - 1'b1;
            default: w_next = addr_o;
        endcase
    end

    // Page counters: cleared under rst_out, otherwise only the selected page moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the page store is a few flops rather than RAM, so it takes the async reset like any register.
            for (int p = 0; p < PAGES; p++) r_page[p] <= '0;
        end else if (rst_out) begin
            for (int p = 0; p < PAGES; p++) r_page[p] <= '0;
        end else if (w_dir != ROT_NONE && w_sel_ok) begin
            r_page[page_sel] <= w_next;
        end
    end

endmodule

// File: tb/tb_board_input_ctrl.sv
// Self-checking bench for board_input_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_board_input_ctrl;

    localparam int DB  = 4;
    localparam int RS  = 3;
    localparam int NCH = 11;
    localparam int HL  = DB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_i, sw_i;
    logic       rot_a, rot_b, rst_req_i, locked_i;
    logic [1:0] page_sel;

    logic [3:0] btn_lvl_w, btn_pulse_w, sw_o_w, btn_lvl_s, btn_pulse_s, sw_o_s;
    logic [4:0] addr_w, addr_s;
    logic       rst_out_w, rst_out_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    board_input_ctrl #(.N_BTN(4), .N_SW(4), .PAGES(4), .ADDR_W(5), .DB_CYCLES(DB),
                       .RST_STRETCH(RS), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .btn_i(btn_i), .sw_i(sw_i), .rot_a(rot_a), .rot_b(rot_b),
        .rst_req_i(rst_req_i), .locked_i(locked_i), .page_sel(page_sel),
        .btn_lvl(btn_lvl_w), .btn_pulse(btn_pulse_w), .sw_o(sw_o_w), .addr_o(addr_w),
        .rst_out(rst_out_w)
    );

    board_input_ctrl #(.N_BTN(4), .N_SW(4), .PAGES(4), .ADDR_W(5), .DB_CYCLES(DB),
                       .RST_STRETCH(RS), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .btn_i(btn_i), .sw_i(sw_i), .rot_a(rot_a), .rot_b(rot_b),
        .rst_req_i(rst_req_i), .locked_i(locked_i), .page_sel(page_sel),
        .btn_lvl(btn_lvl_s), .btn_pulse(btn_pulse_s), .sw_o(sw_o_s), .addr_o(addr_s),
        .rst_out(rst_out_s)
    );

    // ---------------- behavioural model ----------------
    bit m_hist  [NCH][HL];   // raw samples per clock edge, index 0 newest
    bit m_lvl   [NCH];
    bit m_pulse [4];
    bit m_rise_a, m_rise_b;
    int m_pw [4];            // wrapping pages
    int m_ps [4];            // saturating pages
    bit m_lock_prev, m_lock_s;
    int m_since;
    bit m_rst_out;

    function automatic bit raw_of(input int ch);
        if (ch < 4)       return btn_i[ch];
        else if (ch < 8)  return sw_i[ch-4];
        else if (ch == 8) return rot_a;
        else if (ch == 9) return rot_b;
        else              return rst_req_i;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lvl[c] = 0;
            for (int k = 0; k < HL; k++) m_hist[c][k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_pulse[i] = 0; m_pw[i] = 0; m_ps[i] = 0;
        end
        m_rise_a = 0; m_rise_b = 0;
        m_lock_prev = 0; m_lock_s = 0;
        m_since = 0; m_rst_out = 1;
    endtask

    task automatic model_step();
        bit old [NCH];
        bit all_differ;
        bit src;
        int d;
        int p;
        // rotary decision from the previous cycle's debounced edges
        if (m_rst_out) begin
            for (int i = 0; i < 4; i++) begin m_pw[i] = 0; m_ps[i] = 0; end
        end else begin
            d = 0;
            if (m_rise_a && !m_rise_b && !m_lvl[9])      d = -1;
            else if (m_rise_b && !m_rise_a && !m_lvl[8]) d = 1;
            if (d != 0) begin
                p = int'(page_sel);
                m_pw[p] = (m_pw[p] + d + 32) % 32;
                m_ps[p] = m_ps[p] + d;
                if (m_ps[p] < 0)  m_ps[p] = 0;
                if (m_ps[p] > 31) m_ps[p] = 31;
            end
        end
        // a level flips when the last DB synchronised samples all disagree with it
        for (int c = 0; c < NCH; c++) begin
            old[c] = m_lvl[c];
            for (int k = HL - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = raw_of(c);
            all_differ = 1;
            for (int k = 2; k < HL; k++) if (m_hist[c][k] == m_lvl[c]) all_differ = 0;
            if (all_differ) m_lvl[c] = ~m_lvl[c];
        end
        for (int i = 0; i < 4; i++) m_pulse[i] = m_lvl[i] & ~old[i];
        m_rise_a = m_lvl[8] & ~old[8];
        m_rise_b = m_lvl[9] & ~old[9];
        // reset stretch
        m_lock_s    = m_lock_prev;
        m_lock_prev = locked_i;
        src = m_lvl[10] || !m_lock_s;
        if (src) m_since = 0;
        else if (m_since < 1000) m_since++;
        m_rst_out = src || (m_since <= RS);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_btn, e_pulse, e_sw;
        for (int i = 0; i < 4; i++) begin
            e_btn[i] = m_lvl[i]; e_pulse[i] = m_pulse[i]; e_sw[i] = m_lvl[4+i];
        end
        check("btn_lvl_w",   32'(btn_lvl_w),   32'(e_btn));
        check("btn_lvl_s",   32'(btn_lvl_s),   32'(e_btn));
        check("btn_pulse_w", 32'(btn_pulse_w), 32'(e_pulse));
        check("btn_pulse_s", 32'(btn_pulse_s), 32'(e_pulse));
        check("sw_o_w",      32'(sw_o_w),      32'(e_sw));
        check("sw_o_s",      32'(sw_o_s),      32'(e_sw));
        check("addr_wrap",   32'(addr_w),      32'(m_pw[page_sel]));
        check("addr_sat",    32'(addr_s),      32'(m_ps[page_sel]));
        check("rst_out_w",   32'(rst_out_w),   32'(m_rst_out));
        check("rst_out_s",   32'(rst_out_s),   32'(m_rst_out));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // B-first step increments, A-first step decrements.
    task automatic rot_step(input bit inc);
        if (inc) rot_b = 1'b1; else rot_a = 1'b1;
        ticks(8);
        if (inc) rot_a = 1'b1; else rot_b = 1'b1;
        ticks(8);
        if (inc) rot_b = 1'b0; else rot_a = 1'b0;
        ticks(8);
        if (inc) rot_a = 1'b0; else rot_b = 1'b0;
        ticks(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        btn_i = '0; sw_i = '0; rot_a = 0; rot_b = 0;
        rst_req_i = 0; locked_i = 1; page_sel = 2'd0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // initial stretch: lock already high, released 3+2 cycles after reset
        n = 0;
        while (rst_out_w && n < 20) begin tick(); n++; end
        check("rst_init_latency", 32'(n), 32'd5);

        // button debounce latency and single pulse
        btn_i[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!btn_lvl_w[1] && n < 20);
        check("btn_latency", 32'(n), 32'd6);
        check("btn_pulse_on", 32'(btn_pulse_w[1]), 32'd1);
        tick();
        check("btn_pulse_off", 32'(btn_pulse_w[1]), 32'd0);

        // 3-cycle glitch is rejected
        btn_i[2] = 1'b1;
        ticks(3);
        btn_i[2] = 1'b0;
        ticks(10);
        check("btn_glitch", 32'(btn_lvl_w[2]), 32'd0);

        // page 2: decrement from 0 wraps to 31 / saturates at 0
        page_sel = 2'd2;
        rot_step(1'b0);
        check("wrap_dec_to_31", 32'(addr_w), 32'd31);
        check("sat_dec_hold_0", 32'(addr_s), 32'd0);
        rot_step(1'b1);
        check("wrap_inc_to_0", 32'(addr_w), 32'd0);
        check("sat_inc_to_1", 32'(addr_s), 32'd1);
        for (int p = 0; p < 4; p++) begin
            if (p != 2) begin
                page_sel = 2'(p);
                #1;
                check("other_page_untouched", 32'(addr_w), 32'd0);
            end
        end
        page_sel = 2'd2;
        rot_step(1'b1);
        check("wrap_second_step", 32'(addr_w), 32'd1);

        // both phases rising together: no change
        rot_a = 1'b1; rot_b = 1'b1;
        ticks(8);
        rot_a = 1'b0; rot_b = 1'b0;
        ticks(8);
        check("same_cycle_wrap", 32'(addr_w), 32'd1);
        check("same_cycle_sat", 32'(addr_s), 32'd2);

        // page isolation
        page_sel = 2'd1;
        for (int i = 0; i < 7; i++) rot_step(1'b1);
        check("page1_is_7", 32'(addr_w), 32'd7);
        page_sel = 2'd3;
        #1;
        check("page3_zero_latency", 32'(addr_w), 32'd0);
        page_sel = 2'd1;
        #1;
        check("page1_back", 32'(addr_w), 32'd7);

        // lock loss stretch
        locked_i = 1'b0;
        ticks(10);
        locked_i = 1'b1;
        n = 0;
        while (rst_out_w && n < 20) begin tick(); n++; end
        check("lock_stretch_latency", 32'(n), 32'd5);

        // lock glitch mid-stretch restarts the full stretch
        locked_i = 1'b0;
        ticks(4);
        locked_i = 1'b1;
        ticks(3);
        locked_i = 1'b0;
        tick();
        locked_i = 1'b1;
        n = 0;
        while (rst_out_w && n < 20) begin tick(); n++; end
        check("lock_restart_latency", 32'(n), 32'd5);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(4) == 0) btn_i[i] = ~btn_i[i];
                if ($urandom_range(5) == 0) sw_i[i]  = ~sw_i[i];
            end
            if ($urandom_range(7) == 0) rot_a = ~rot_a;
            if ($urandom_range(7) == 0) rot_b = ~rot_b;
            if ($urandom_range(9) == 0) page_sel = 2'($urandom_range(3));
            if (rst_req_i) begin
                if ($urandom_range(9) == 0) rst_req_i = 1'b0;
            end else if ($urandom_range(300) == 0) begin
                rst_req_i = 1'b1;
            end
            if (locked_i) begin
                if ($urandom_range(300) == 0) locked_i = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                locked_i = 1'b1;
            end
            tick();
        end

        // async reset in the middle of a debounce
        rst_req_i = 0; locked_i = 1; rot_a = 0; rot_b = 0;
        btn_i = 4'b0011; sw_i = 4'b1010; page_sel = 2'd0;
        ticks(12);
        n = 0;
        while (rst_out_w && n < 40) begin tick(); n++; end
        check("rst_release_bound", 32'(rst_out_w), 32'd0);
        rot_step(1'b1);
        btn_i[3] = 1'b1;
        ticks(3);
        #2;
        rst = 1'b1;
        #1;
        check("async_btn_lvl",   32'(btn_lvl_w),   32'd0);
        check("async_btn_pulse", 32'(btn_pulse_w), 32'd0);
        check("async_sw_o",      32'(sw_o_w),      32'd0);
        check("async_addr_w",    32'(addr_w),      32'd0);
        check("async_addr_s",    32'(addr_s),      32'd0);
        check("async_rst_out",   32'(rst_out_w),   32'd1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(12);
        check("debounce_after_reset", 32'(btn_lvl_w), 32'hb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
